minicpu_mc: RTL
===============

MINICPU_MC -- requirements
Module: minicpu_mc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-002 SHALL have parameter ADDR_W, default 32, width of PC and of both SRAM address buses.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset: synchronous, active-high.
REQ-005 inst_req  out  1  instruction fetch request, held until inst_rvalid.
REQ-006 inst_addr  out  ADDR_W  fetch address, equal to the PC.
REQ-007 inst_rdata  in  32  fetched instruction.
REQ-008 inst_rvalid  in  1  inst_rdata valid; same-cycle response allowed.
REQ-009 data_req  out  1  data access request, held until data_ack.
REQ-010 data_we  out  1  1 = store, 0 = load.
REQ-011 data_addr  out  ADDR_W  data address.
REQ-012 data_wdata  out  32  store data.
REQ-013 data_rdata  in  32  load data, valid with data_ack.
REQ-014 data_ack  in  1  access complete.
REQ-015 wb_we  out  1  one-cycle pulse on every register-file write.
REQ-016 wb_pc  out  ADDR_W  PC of the retiring instruction.
REQ-017 wb_wnum  out  5  written register number.
REQ-018 wb_wdata  out  32  written data.
REQ-019 halted  out  1  high while in HALT.

Function
REQ-020 SHALL be a multi-cycle FSM with states IF, EX, MEM, WB, HALT, one-hot or binary.
REQ-021 IF SHALL behave as follows.
- Assert inst_req with inst_addr = PC.
- On inst_rvalid, latch IR and go to EX.
- Otherwise stay in IF.
REQ-022 EX SHALL read rj and rd/rk from the 32x32 regfile, decode IR, and latch the result.
REQ-023 SHALL decode add.w (IR[31:15]=0x00020), sub.w (0x00022), addi.w (IR[31:22]=0x00a), ld.w (0x0a2), st.w (0x0a6), lu12i.w (IR[31:25]=0x0a), beq (IR[31:26]=0x16), bne (0x17) and b (0x14).
REQ-024 Operand rules SHALL be as follows.
- addi, ld and st use sext(IR[21:10]).
- lu12i.w result is {IR[24:5], 12'b0}.
- st.w and branches read rd on port 2.
- Arithmetic is modulo 2^32; overflow is ignored.
REQ-025 Branch targets SHALL be computed as follows.
- beq/bne target = PC + sext({IR[25:10],2'b00}).
- b target = PC + sext({IR[9:0],IR[25:10],2'b00}).
- A taken branch loads the target, otherwise PC+4.
- All branches go from EX directly to IF and produce no wb_we.
REQ-026 ld/st SHALL go from EX to MEM.
REQ-027 MEM SHALL behave as follows.
- Hold data_req, data_we, data_addr = rj + imm and data_wdata = rd value until data_ack.
- ld latches data_rdata and goes to WB.
- st sets PC <= PC+4 and goes to IF.
REQ-028 ALU ops SHALL go from EX to WB.
REQ-029 WB SHALL write the regfile, pulse wb_* for one cycle, set PC <= PC+4 and go to IF.
REQ-030 Writes to r0 SHALL be discarded, r0 reads SHALL return 0, and wb_we SHALL still pulse with wb_wnum=0.
REQ-031 Any undecoded IR SHALL go from EX to HALT.
REQ-032 HALT SHALL be sticky until reset: halted=1, no requests, PC frozen.
REQ-033 Minimum latency at zero wait SHALL be as follows.
- ALU instruction: 3 cycles.
- ld: 4 cycles.
- st: 3 cycles.
- Branch: 2 cycles.
- Each wait cycle of inst_rvalid or data_ack adds 1 cycle.
REQ-034 inst_req and data_req SHALL never be asserted in the same cycle.
REQ-035 Request outputs SHALL be stable while waiting.
REQ-036 inst_rvalid and data_ack SHALL be ignored outside IF and MEM respectively.

Reset
REQ-037 While reset=1 SHALL hold the following.
- state=IF, PC=RESET_PC, IR=0.
- inst_req=0 and data_req=0.
- wb_we=0 and halted=0.
REQ-038 In the first cycle after reset deasserts, SHALL assert inst_req with inst_addr=RESET_PC.
REQ-039 Reset mid-request SHALL abort the access without any state update.
REQ-040 Regfile contents SHALL NOT be reset.

Structure
REQ-041 Opcode match constants, the state encoding and RESET_PC default SHALL live in shared package minicpu_pkg.
REQ-042 SHALL instantiate the existing regfile sub-module, with 2 async read ports and 1 sync write port.
REQ-043 Decode and ALU SHALL stay inline.

Verification
REQ-044 Zero-wait ALU run SHALL pass.
- Stimulus: addi.w r1,r0,5; addi.w r2,r0,-3; add.w r3,r1,r2; sub.w r4,r1,r2.
- Response: wb pulses r1=5, r2=0xfffffffd, r3=2, r4=8.
- Pulses are exactly 3 cycles apart.
REQ-045 Memory run with a 2-wait data slave SHALL pass.
- Stimulus: lu12i.w r5,0x1 (r5=0x00001000); st.w r3,r5,8; ld.w r6,r5,8.
- Response: data_addr=0x00001008 and r6=2.
- ld takes 6 cycles and data_req stays stable.
REQ-046 Branches SHALL pass.
- bne r1,r2,+8 at 0x1c000010 next fetches 0x1c000018.
- beq r1,r1,-4 fetches 0x1c00000c.
- b with offset 0x100 at PC P fetches P+0x100.
- No wb_we pulse for any of them.
REQ-047 r0 writes SHALL be discarded: addi.w r0,r0,7 then add.w r7,r0,r0 -> r7=0.
REQ-048 Illegal instruction SHALL halt the core.
- Stimulus: 0xffffffff.
- Response: halted=1 in the cycle after EX, with no further requests for 20 cycles.
- Reset returns the core to fetching RESET_PC.
REQ-049 Reset mid-fetch SHALL recover cleanly.
- Stimulus: assert reset while inst_req is waiting 3 cycles.
- Response: inst_req=0 during reset, then a refetch of 0x1c000000 with no wb_we.

Source files
------------

// File: rtl/minicpu_pkg.sv
// Shared definitions for the multi-cycle mini CPU: state encoding, opcode
// match constants and the default boot address.
package minicpu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_EX   = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  // IR[31:15]
  localparam logic [16:0] OP_ADD_W   = 17'h00020;
  localparam logic [16:0] OP_SUB_W   = 17'h00022;
  // IR[31:22]
  localparam logic [9:0]  OP_ADDI_W  = 10'h00a;
  localparam logic [9:0]  OP_LD_W    = 10'h0a2;
  localparam logic [9:0]  OP_ST_W    = 10'h0a6;
  // IR[31:25]
  localparam logic [6:0]  OP_LU12I_W = 7'h0a;
  // IR[31:26]
  localparam logic [5:0]  OP_BEQ     = 6'h16;
  localparam logic [5:0]  OP_BNE     = 6'h17;
  localparam logic [5:0]  OP_B       = 6'h14;

endpackage

// File: rtl/minicpu_mc_if.sv
// Instruction fetch, data access and retirement (write-back) signals of the
// mini CPU; master is the core, slave is the memory/trace side.
interface minicpu_mc_if #(
  parameter int ADDR_W = 32
) ();

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_rdata;
  logic              inst_rvalid;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              data_ack;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_pc;
  logic [4:0]        wb_wnum;
  logic [31:0]       wb_wdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_rdata, inst_rvalid,
    output data_req, data_we, data_addr, data_wdata,
    input  data_rdata, data_ack,
    output wb_we, wb_pc, wb_wnum, wb_wdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_rdata, inst_rvalid,
    input  data_req, data_we, data_addr, data_wdata,
    output data_rdata, data_ack,
    input  wb_we, wb_pc, wb_wnum, wb_wdata
  );

endinterface

// File: rtl/minicpu_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// r0 reads as zero and ignores writes; contents are not reset.
module minicpu_mc_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];

endmodule

// File: rtl/minicpu_mc.sv
// Multi-cycle mini CPU core (LoongArch subset) with fetch / execute / memory /
// write-back sequencing and a sticky halt on undecoded instructions.
//
// state  | meaning
// S_IF   | fetch: inst_req at PC, wait for inst_rvalid, latch IR
// S_EX   | decode, read regfile, compute ALU result / address / branch target
// S_MEM  | data access held until data_ack
// S_WB   | regfile write, one-cycle wb_* pulse, PC += 4
// S_HALT | undecoded instruction seen; sticky until reset
module minicpu_mc
  import minicpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  minicpu_mc_if.master bus,
  output logic         halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       res_q, res_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic is_add, is_sub, is_addi, is_ld, is_st, is_lu12i, is_beq, is_bne, is_b;
  logic is_alu;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] imm12, br_off, b_off, alu_res;
  logic [ADDR_W-1:0] pc_plus4;
  logic rf_we;

  assign is_add   = (ir_q[31:15] == OP_ADD_W);
  assign is_sub   = (ir_q[31:15] == OP_SUB_W);
  assign is_addi  = (ir_q[31:22] == OP_ADDI_W);
  assign is_ld    = (ir_q[31:22] == OP_LD_W);
  assign is_st    = (ir_q[31:22] == OP_ST_W);
  assign is_lu12i = (ir_q[31:25] == OP_LU12I_W);
  assign is_beq   = (ir_q[31:26] == OP_BEQ);
  assign is_bne   = (ir_q[31:26] == OP_BNE);
  assign is_b     = (ir_q[31:26] == OP_B);
  assign is_alu   = is_add | is_sub | is_addi | is_lu12i;

  // Stores and compare-branches take their second operand from the rd field.
  assign rf_raddr2 = (is_st | is_beq | is_bne) ? ir_q[4:0] : ir_q[14:10];

  assign imm12    = {{20{ir_q[21]}}, ir_q[21:10]};
  assign br_off   = {{14{ir_q[25]}}, ir_q[25:10], 2'b00};
  assign b_off    = {{4{ir_q[9]}}, ir_q[9:0], ir_q[25:10], 2'b00};
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    alu_res = 32'd0;
    if (is_add)        alu_res = rf_rdata1 + rf_rdata2;
    else if (is_sub)   alu_res = rf_rdata1 - rf_rdata2;
    else if (is_addi)  alu_res = rf_rdata1 + imm12;
    else if (is_lu12i) alu_res = {ir_q[24:5], 12'b0};
  end

  minicpu_mc_regfile u_regfile (
    .clk    (clk),
    .raddr1 (ir_q[9:5]),
    .rdata1 (rf_rdata1),
    .raddr2 (rf_raddr2),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (ir_q[4:0]),
    .wdata  (res_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_ff @(posedge clk) begin
    res_q   <= res_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IF: begin
        if (bus.inst_rvalid) begin
          ir_d    = bus.inst_rdata;
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_alu) begin
          res_d   = alu_res;
          state_d = S_WB;
        end else if (is_ld || is_st) begin
          addr_d  = ADDR_W'(rf_rdata1 + imm12);
          wdata_d = rf_rdata2;
          state_d = S_MEM;
        end else if (is_beq || is_bne) begin
          pc_d    = ((rf_rdata1 == rf_rdata2) == is_beq) ? pc_q + ADDR_W'(br_off)
                                                         : pc_plus4;
          state_d = S_IF;
        end else if (is_b) begin
          pc_d    = pc_q + ADDR_W'(b_off);
          state_d = S_IF;
        end else begin
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        if (bus.data_ack) begin
          if (is_ld) begin
            res_d   = bus.data_rdata;
            state_d = S_WB;
          end else begin
            pc_d    = pc_plus4;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_plus4;
        state_d = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Outputs are masked by reset so nothing escapes while the state is re-seeded.
  always_comb begin
    bus.inst_req   = (state_q == S_IF) && !reset;
    bus.inst_addr  = pc_q;
    bus.data_req   = (state_q == S_MEM) && !reset;
    bus.data_we    = (state_q == S_MEM) && is_st;
    bus.data_addr  = addr_q;
    bus.data_wdata = wdata_q;
    bus.wb_we      = (state_q == S_WB) && !reset;
    bus.wb_pc      = pc_q;
    bus.wb_wnum    = ir_q[4:0];
    bus.wb_wdata   = res_q;
    halted         = (state_q == S_HALT) && !reset;
    rf_we          = (state_q == S_WB) && !reset;
  end

endmodule
